// File: rtl/network_bank_out.sv
// Return-path crossbar: delays each bank's lane select by the read latency,
// then steers bank read data back to the lane that issued the read.
module network_bank_out #(
  parameter int P          = 2,
  parameter int MAP        = 2,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*P*MAP-1:0]           sel_BI_bus,
  input  logic [2*P-1:0]               bank_rd_en,
  input  logic                         flush,
  input  logic [2*P*DATA_WIDTH-1:0]    bank_dout_bus,
  output logic [2*P*DATA_WIDTH-1:0]    data_out_bus,
  output logic [2*P-1:0]               data_valid,
  output logic                         collision_err
);

  localparam int N = 2 * P;

  logic [RD_LAT-1:0][N*MAP-1:0] sel_q;
  logic [RD_LAT-1:0][N-1:0]     en_q;

  logic [N*MAP-1:0]             d_sel;
  logic [N-1:0]                 d_en;

  logic [N-1:0][DATA_WIDTH-1:0] word;
  logic [N-1:0][DATA_WIDTH-1:0] data_q;
  logic [N-1:0]                 hit;
  logic [N-1:0]                 valid_q;
  logic                         coll;
  logic                         err_q;

  assign d_sel = sel_q[RD_LAT-1];
  assign d_en  = en_q[RD_LAT-1];

  // Scan banks low to high so the lowest bank claims a contested lane.
  always_comb begin
    word = '0;
    hit  = '0;
    coll = 1'b0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        if (d_en[k] && d_sel[k*MAP +: MAP] == MAP'(j)) begin
          if (hit[j]) begin
            coll = 1'b1;
          end else begin
            hit[j]  = 1'b1;
            word[j] = bank_dout_bus[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      en_q    <= '0;
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sel_q[0] <= sel_BI_bus;
      en_q[0]  <= flush ? '0 : bank_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        sel_q[i] <= sel_q[i-1];
        en_q[i]  <= flush ? '0 : en_q[i-1];
      end
      data_q  <= flush ? '0 : word;
      valid_q <= flush ? '0 : hit;
      // Sticky: flush must not hide a collision seen this cycle.
      if (coll) err_q <= 1'b1;
    end
  end

  assign data_out_bus  = data_q;
  assign data_valid    = valid_q;
  assign collision_err = err_q;

endmodule
